// File: rtl/wave_voice_pkg.sv
// Shared encodings for the wave_voice tone generator: waveform/duty codes,
// FSM states and the noise LFSR constants (used when WAVE_VOICE_NOISE_EN is defined).
package wave_voice_pkg;

  typedef enum logic [1:0] {
    MODE_PULSE = 2'b00,
    MODE_TRI   = 2'b01,
    MODE_SAW   = 2'b10,
    MODE_NOISE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    DUTY_50 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_12 = 2'b10,
    DUTY_75 = 2'b11
  } duty_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_CALC = 2'b10,
    ST_PEND = 2'b11
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/wave_step_div.sv
// Serial restoring divider for the waveform step size: quotient = dividend / divisor,
// one quotient bit per cycle, first bit taken in the start cycle, done after N cycles.
module wave_step_div
  import wave_voice_pkg::*;
#(
  parameter int N = 18,
  parameter int D = 32
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N);

  logic [D:0]    rem, rem_in, trial, diff;
  logic [N-1:0]  q, q_in;
  logic [D-1:0]  dsr, dsr_in;
  logic [CW-1:0] cnt;
  logic          busy, bit_ok;

  always_comb begin
    rem_in = start ? '0 : rem;
    q_in   = start ? dividend : q;
    dsr_in = start ? divisor : dsr;
    trial  = {rem_in[D-1:0], q_in[N-1]};
    diff   = trial - {1'b0, dsr_in};
    bit_ok = trial >= {1'b0, dsr_in};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      q    <= '0;
      dsr  <= '0;
    end else if (start || (busy && cnt != '0)) begin
      busy <= 1'b1;
      cnt  <= start ? CW'(N - 1) : cnt - 1'b1;
      rem  <= bit_ok ? diff : trial;
      q    <= {q_in[N-2:0], bit_ok};
      dsr  <= dsr_in;
    end else if (busy) begin
      busy <= 1'b0;
    end
  end

  assign done     = busy && (cnt == '0);
  assign quotient = q;

endmodule

// File: rtl/wave_voice.sv
// Single tone voice: pulse/triangle/saw/noise with glitch-free reconfiguration at
// period wrap. Noise mode is built only when WAVE_VOICE_NOISE_EN is defined.
module wave_voice
  import wave_voice_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [1:0]        cfg_duty,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DATA_W-1:0] cfg_amplitude,
  output logic [DATA_W-1:0] sample_out,
  output logic              cycle_start
);
  localparam int SW = DATA_W + 2;
  localparam logic [DATA_W-1:0] AMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  count, cnt_nxt, act_period, pend_period;
  mode_t             act_mode, pend_mode;
  duty_t             act_duty, pend_duty;
  logic [DATA_W-1:0] act_amp, pend_amp, amp_in;
  logic [DATA_W-1:0] samp_run, samp_new, samp_start;
  logic [SW-1:0]     act_step, pend_step, div_dividend, div_q;
  logic              xfer, running, wrap, apply, div_done;
  logic              noise_run, noise_new;

`ifdef WAVE_VOICE_NOISE_EN
  localparam bit NOISE_EN = 1'b1;
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt  = lfsr_step(lfsr);
  assign noise_new = lfsr[0];
  assign noise_run = wrap ? lfsr_nxt[0] : lfsr[0];
  always_ff @(posedge CLOCK_50) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (wrap && !apply && act_mode == MODE_NOISE) lfsr <= lfsr_nxt;
  end
`else
  localparam bit NOISE_EN = 1'b0;
  assign noise_new = 1'b0;
  assign noise_run = 1'b0;
`endif

  // Sample at count c; saw/triangle are incremental, so prev is the current output.
  function automatic logic [DATA_W-1:0] wave_fn(
    input mode_t m, input duty_t d, input logic [CNT_W-1:0] p,
    input logic [DATA_W-1:0] a, input logic [SW-1:0] s,
    input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] prev, input logic nb);
    logic [CNT_W-1:0] thr;
    logic [SW-1:0]    pe, ne, acc;
    pe  = {2'b00, a};
    ne  = -pe;
    acc = {{2{prev[DATA_W-1]}}, prev};
    case (d)
      DUTY_50: thr = p >> 1;
      DUTY_25: thr = p >> 2;
      DUTY_12: thr = p >> 3;
      default: thr = p - (p >> 2);
    endcase
    case (m)
      MODE_PULSE: wave_fn = (c < thr) ? pe[DATA_W-1:0] : ne[DATA_W-1:0];
      MODE_SAW: begin
        acc = acc + s;
        wave_fn = (c == '0) ? ne[DATA_W-1:0] : acc[DATA_W-1:0];
      end
      MODE_TRI: begin
        acc = (c <= (p >> 1)) ? acc + s : acc - s;
        wave_fn = (c == '0) ? ne[DATA_W-1:0] : acc[DATA_W-1:0];
      end
      default: wave_fn = NOISE_EN ? (nb ? pe[DATA_W-1:0] : ne[DATA_W-1:0]) : '0;
    endcase
  endfunction

  assign xfer   = cfg_valid && cfg_ready;
  assign amp_in = cfg_amplitude[DATA_W-1] ? AMP_MAX : cfg_amplitude;

  always_comb begin
    case (mode_t'(cfg_mode))
      MODE_SAW: div_dividend = {1'b0, amp_in, 1'b0};
      MODE_TRI: div_dividend = {amp_in, 2'b00};
      default:  div_dividend = '0;
    endcase
  end

  wave_step_div #(.N(SW), .D(CNT_W)) u_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (xfer),
    .dividend (div_dividend),
    .divisor  (cfg_period),
    .done     (div_done),
    .quotient (div_q)
  );

  // A finished config is applied at the old waveform's wrap, or at once when nothing is
  // playing (silent period or enable low), so a pending config is never dropped.
  always_comb begin
    running   = enable && (act_period != '0) && (state != ST_IDLE);
    wrap      = running && (count == act_period - 1'b1);
    cnt_nxt   = (wrap || state == ST_IDLE) ? '0 : count + 1'b1;
    apply     = ((state == ST_CALC && div_done) || state == ST_PEND) && (!running || wrap);
    pend_step = (pend_period == '0) ? '0 : div_q;
    nxt_state = state;
    case (state)
      ST_IDLE: if (xfer) nxt_state = ST_CALC;
               else if (enable && act_period != '0) nxt_state = ST_RUN;
      ST_RUN:  if (xfer) nxt_state = ST_CALC;
               else if (!enable) nxt_state = ST_IDLE;
      default: if (apply) nxt_state = (enable && pend_period != '0) ? ST_RUN : ST_IDLE;
               else if (state == ST_CALC && div_done) nxt_state = ST_PEND;
    endcase
  end

  assign samp_run   = wave_fn(act_mode, act_duty, act_period, act_amp, act_step,
                              cnt_nxt, sample_out, noise_run);
  assign samp_new   = wave_fn(pend_mode, pend_duty, pend_period, pend_amp, pend_step,
                              '0, sample_out, noise_new);
  assign samp_start = wave_fn(act_mode, act_duty, act_period, act_amp, act_step,
                              '0, sample_out, noise_new);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      cfg_ready   <= 1'b1;
      count       <= '0;
      sample_out  <= '0;
      cycle_start <= 1'b0;
      act_period  <= '0;
      act_mode    <= MODE_PULSE;
      act_duty    <= DUTY_50;
      act_amp     <= '0;
      act_step    <= '0;
      pend_period <= '0;
      pend_mode   <= MODE_PULSE;
      pend_duty   <= DUTY_50;
      pend_amp    <= '0;
    end else begin
      state     <= nxt_state;
      cfg_ready <= (nxt_state == ST_IDLE) || (nxt_state == ST_RUN);
      if (xfer) begin
        pend_period <= cfg_period;
        pend_mode   <= mode_t'(cfg_mode);
        pend_duty   <= duty_t'(cfg_duty);
        pend_amp    <= amp_in;
      end
      if (apply) begin
        act_period <= pend_period;
        act_mode   <= pend_mode;
        act_duty   <= pend_duty;
        act_amp    <= pend_amp;
        act_step   <= pend_step;
      end
      if (apply && nxt_state == ST_RUN) begin
        count       <= '0;
        sample_out  <= samp_new;
        cycle_start <= 1'b1;
      end else if (running && !apply) begin
        count       <= cnt_nxt;
        sample_out  <= samp_run;
        cycle_start <= (cnt_nxt == '0);
      end else if (state == ST_IDLE && nxt_state == ST_RUN) begin
        count       <= '0;
        sample_out  <= samp_start;
        cycle_start <= 1'b1;
      end else begin
        count       <= '0;
        sample_out  <= '0;
        cycle_start <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wave_voice.md
WAVE_VOICE -- requirements
Module: wave_voice

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter CNT_W, default 32, period counter width.
REQ-003 SHALL have port CLOCK_50  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  run/hold; low forces IDLE.
REQ-006 SHALL have port cfg_valid  in  1  config offer.
REQ-007 SHALL have port cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready.
REQ-008 SHALL have port cfg_mode  in  2  waveform: 00 pulse, 01 triangle, 10 sawtooth, 11 noise.
REQ-009 SHALL have port cfg_duty  in  2  pulse duty: 00 50%, 01 25%, 10 12.5%, 11 75%.
REQ-010 SHALL have port cfg_period  in  CNT_W  period in clock cycles; 0 means silent.
REQ-011 SHALL have port cfg_amplitude  in  DATA_W  unsigned peak magnitude.
REQ-012 SHALL have port sample_out  out  DATA_W  signed registered sample.
REQ-013 SHALL have port cycle_start  out  1  one-cycle strobe at count 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, CALC, PEND.
- IDLE: active period 0 or enable low; count held 0; sample_out 0; cycle_start 0.
- RUN: count 0..period-1, wraps to 0 after period-1.
- CALC: entered on config transfer; serial divide, exactly DATA_W+2 cycles; old waveform continues.
- PEND: new config held; applied on the cycle count==period-1, so next cycle has count 0 with new settings; from IDLE, applied directly after CALC.
REQ-015 SHALL drive cfg_ready high only in IDLE and RUN.
REQ-016 SHALL clamp cfg_amplitude to 2^(DATA_W-1)-1 at transfer.
REQ-017 SHALL compute step = floor(2*amp/period) for saw and floor(4*amp/period) for triangle; step 0 when period 0.
REQ-018 SHALL update sample_out and count in the same cycle, so sample_out = f(count).
- Pulse: +amp while count < threshold, else -amp; thresholds period>>1, >>2, >>3, period-(period>>2).
- Saw: count 0 -> -amp; each later count adds step.
- Triangle: count 0 -> -amp; count 1..period>>1 adds step; above that subtracts step.
- Noise: +amp if lfsr[0] else -amp; LFSR advances only at wrap.
REQ-019 SHALL assert cycle_start for one cycle whenever count==0 in RUN.
REQ-020 SHALL treat period 1 as count fixed 0, cycle_start high every cycle.
REQ-021 SHALL, on enable deassert, go IDLE next cycle and restart at count 0 on reassert.

Reset
REQ-022 SHALL on reset set state IDLE, count 0, sample_out 0, cycle_start 0, cfg_ready 1, active period 0, mode 00, LFSR 16'hACE1.
REQ-023 SHALL on reset during CALC or PEND discard the pending config.

Configuration
REQ-024 SHALL honour macro WAVE_VOICE_NOISE_EN: defined -> 16-bit Galois LFSR, taps 16'hB400, noise mode as REQ-018; undefined -> no LFSR, mode 11 outputs 0 and other modes unchanged.

Structure
REQ-025 SHALL place mode codes, duty codes, FSM state encoding and LFSR seed/taps in shared package wave_voice_pkg.
REQ-026 SHALL implement the divider as sub-module wave_step_div: start/done handshake, fixed DATA_W+2 cycle latency.

Verification (DATA_W=16)
REQ-027 SHALL cover pulse: period 8, amp 1000, duty 00 -> four +1000 then four -1000; cycle_start every 8 cycles.
REQ-028 SHALL cover saw: period 4, amp 100 -> -100,-50,0,50 repeating.
REQ-029 SHALL cover triangle: period 8, amp 100 -> -100,-50,0,50,100,50,0,-50 repeating.
REQ-030 SHALL cover mid-period reconfig: cfg_ready low 18 cycles; old waveform holds until wrap; new one starts at next count 0.
REQ-031 SHALL cover reset asserted mid-CALC -> next cycle sample_out 0, cfg_ready 1; pending config not applied.
REQ-032 SHALL cover noise with macro: period 4, amp 500 -> output changes only at cycle_start and follows LFSR bit 0 from seed 16'hACE1; without macro -> constant 0.
